// File: rtl/alu_div32.sv
// ---------------------------------------------------------------------------
// alu_div32 : sequential 32-bit signed divider (restoring shift-subtract)
//
// One quotient bit is produced per clock. Each trial subtraction runs through
// a cla32bit instance fed with the inverted divisor and a carry-in of 1, so
// the adder carry-out directly answers "partial remainder >= divisor".
// Results are truncated toward zero; the remainder takes the dividend sign.
//
// Ports
//   clock        in   1   rising-edge clock
//   clear        in   1   asynchronous, active-high reset
//   start        in   1   request, sampled only while idle
//   dividend     in  32   signed numerator, sampled with start
//   divisor      in  32   signed denominator, sampled with start
//   busy         out  1   high while a division is in progress
//   done         out  1   one-cycle pulse when quotient/remainder are valid
//   quotient     out 32   signed quotient (feeds LO)
//   remainder    out 32   signed remainder (feeds HI)
//   div_by_zero  out  1   set with done when the divisor was zero
// ---------------------------------------------------------------------------

// 32-bit carry-lookahead adder: eight 4-bit lookahead groups, group carries
// chained through each group's generate/propagate terms.
module cla32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g_s;
   logic [31:0] p_s;
   logic [32:0] c_s;

   assign g_s  = a & b;
   assign p_s  = a ^ b;
   assign sum  = p_s ^ c_s[31:0];
   assign cout = c_s[32];

   // Carry lookahead: every carry inside a group is formed from that group's
   // incoming carry, never from its neighbour bit's carry.
   always_comb begin
      c_s    = {33{1'b0}};
      c_s[0] = cin;
      for (int k = 0; k < 8; k++) begin
         c_s[4*k+1] = g_s[4*k]
                    | (p_s[4*k] & c_s[4*k]);
         c_s[4*k+2] = g_s[4*k+1]
                    | (p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
         c_s[4*k+3] = g_s[4*k+2]
                    | (p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
         c_s[4*k+4] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      end
   end

endmodule

module alu_div32 (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      state_r, state_nx_s;
   logic [4:0]  count_r, count_nx_s;
   logic [31:0] q_r, q_nx_s;          // dividend shifting out / quotient shifting in
   logic [31:0] m_r, m_nx_s;          // |divisor|
   logic [31:0] r_r, r_nx_s;          // partial remainder
   logic        sign_q_r, sign_q_nx_s;
   logic        sign_r_r, sign_r_nx_s;
   logic        pend_r, pend_nx_s;    // divide-by-zero result due on the next edge
   logic        busy_nx_s, done_nx_s, dz_nx_s;
   logic [31:0] quot_nx_s, rem_nx_s;
   logic [31:0] trial_s, diff_s;
   logic        cout_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // |v|; the most negative value maps onto 32'h80000000, which is still the
   // correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

   assign trial_s = {r_r[30:0], q_r[31]};

   // R stays below M <= 2^31, so the shifted trial value always fits 32 bits.
   cla32bit u_sub (
      .a    (trial_s),
      .b    (~m_r),
      .cin  (1'b1),
      .sum  (diff_s),
      .cout (cout_s)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_nx_s  = state_r;
      count_nx_s  = count_r;
      q_nx_s      = q_r;
      m_nx_s      = m_r;
      r_nx_s      = r_r;
      sign_q_nx_s = sign_q_r;
      sign_r_nx_s = sign_r_r;
      pend_nx_s   = 1'b0;
      busy_nx_s   = busy;
      done_nx_s   = 1'b0;
      dz_nx_s     = div_by_zero;
      quot_nx_s   = quotient;
      rem_nx_s    = remainder;

      // A divide-by-zero accepted last edge publishes its result now; the
      // dividend was parked in q_r so the inputs could change meanwhile.
      if (pend_r) begin
         quot_nx_s = 32'hFFFF_FFFF;
         rem_nx_s  = q_r;
         dz_nx_s   = 1'b1;
         done_nx_s = 1'b1;
      end else begin
         dz_nx_s   = div_by_zero;
      end

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (divisor == 32'd0) begin
                  pend_nx_s = 1'b1;
                  q_nx_s    = dividend;
               end else begin
                  q_nx_s      = abs32(dividend);
                  m_nx_s      = abs32(divisor);
                  r_nx_s      = 32'd0;
                  sign_q_nx_s = dividend[31] ^ divisor[31];
                  sign_r_nx_s = dividend[31];
                  count_nx_s  = 5'd31;
                  busy_nx_s   = 1'b1;
                  // Keeps a pending zero-divide flag visible alongside its done.
                  dz_nx_s     = pend_r;
                  state_nx_s  = ST_RUN;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end

         ST_RUN: begin
            // Carry-out of T + ~M + 1 is set exactly when T >= M.
            if (cout_s) begin
               r_nx_s = diff_s;
               q_nx_s = {q_r[30:0], 1'b1};
            end else begin
               r_nx_s = trial_s;
               q_nx_s = {q_r[30:0], 1'b0};
            end
            if (count_r == 5'd0) begin
               state_nx_s = ST_FIX;
            end else begin
               count_nx_s = count_r - 5'd1;
            end
         end

         ST_FIX: begin
            quot_nx_s  = sign_q_r ? neg32(q_r) : q_r;
            rem_nx_s   = sign_r_r ? neg32(r_r) : r_r;
            dz_nx_s    = 1'b0;
            done_nx_s  = 1'b1;
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
         end

         default: begin
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; clear aborts any division in flight.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_r     <= ST_IDLE;
         count_r     <= 5'd0;
         q_r         <= 32'd0;
         m_r         <= 32'd0;
         r_r         <= 32'd0;
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         pend_r      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= 32'd0;
         remainder   <= 32'd0;
      end else begin
         state_r     <= state_nx_s;
         count_r     <= count_nx_s;
         q_r         <= q_nx_s;
         m_r         <= m_nx_s;
         r_r         <= r_nx_s;
         sign_q_r    <= sign_q_nx_s;
         sign_r_r    <= sign_r_nx_s;
         pend_r      <= pend_nx_s;
         busy        <= busy_nx_s;
         done        <= done_nx_s;
         div_by_zero <= dz_nx_s;
         quotient    <= quot_nx_s;
         remainder   <= rem_nx_s;
      end
   end

endmodule
